// File: rtl/proc_io_pkg.sv
// proc_io_pkg: shared entry sizing and tagged-entry type for the processor I/O FIFOs
// Contents: entry_w() gives the packed {addr, data} width; io_entry_t is the
// tagged entry at the default processor configuration (NUBITS=16, NUIOOU=2).
package proc_io_pkg;
    localparam int DEF_NUBITS = 16;
    localparam int DEF_NBADDR = 1;

    function automatic int entry_w(input int nubits, input int nbaddr);
        return nubits + nbaddr;
    endfunction

    typedef struct packed {
        logic [DEF_NBADDR-1:0] addr;
        logic [DEF_NUBITS-1:0] data;
    } io_entry_t;
endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: storage with one synchronous write port and one combinational read port
// Ports: clk; we/waddr/wdata write on the rising edge; raddr/rdata read combinationally.
// Contents are never reset.
module fifo_ram_2p #(
    parameter int W  = 17,
    parameter int D  = 8,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [D];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/proc_out_fifo.sv
// proc_out_fifo: tagged show-ahead FIFO between the processor output port and a valid/ready sink
// Ports: clk, rst (sync, active-high); out_en/addr_out/io_out processor writes;
// m_valid/m_ready/m_data/m_addr output stream; full/empty/level occupancy;
// ovf sticky drop flag with ovf_clr; dropcnt (16-bit saturating drop count)
// only when PROC_OUT_FIFO_DROPCNT_EN is defined.
module proc_out_fifo
    import proc_io_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 8,
    parameter int NBADDR = $clog2(NUIOOU),
    parameter int FDEPW  = $clog2(FDEPTH)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PROC_OUT_FIFO_DROPCNT_EN
    output logic [15:0]       dropcnt,
`endif
    input  logic              out_en,
    input  logic [NBADDR-1:0] addr_out,
    input  logic [NUBITS-1:0] io_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [NUBITS-1:0] m_data,
    output logic [NBADDR-1:0] m_addr,
    output logic              full,
    output logic              empty,
    output logic [FDEPW:0]    level,
    output logic              ovf,
    input  logic              ovf_clr
);
    localparam int EW = entry_w(NUBITS, NBADDR);

    logic [FDEPW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [FDEPW:0]   lvl_nxt;
    logic [EW-1:0]    ram_q, head;
    logic             push, pop, drop, bypass;

    assign pop     = m_valid & m_ready;
    assign push    = out_en & (~full | pop);
    assign drop    = out_en & full & ~pop;
    assign rd_nxt  = pop ? rd_ptr + FDEPW'(1) : rd_ptr;
    assign lvl_nxt = (push & ~pop) ? level + (FDEPW+1)'(1) :
                     (pop & ~push) ? level - (FDEPW+1)'(1) : level;
    // The incoming word becomes the head when it lands in an empty FIFO (or one
    // being emptied this cycle); the RAM does not hold it yet, so forward it.
    assign bypass  = push & (level == '0 | (level == (FDEPW+1)'(1) & pop));
    assign head    = bypass ? {addr_out, io_out} : ram_q;

    fifo_ram_2p #(.W(EW), .D(FDEPTH), .AW(FDEPW)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({addr_out, io_out}),
        .raddr (rd_nxt),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            m_valid <= 1'b0;
            ovf     <= 1'b0;
            m_data  <= '0;
            m_addr  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FDEPW'(1);
            rd_ptr  <= rd_nxt;
            level   <= lvl_nxt;
            empty   <= lvl_nxt == '0;
            full    <= lvl_nxt == (FDEPW+1)'(FDEPTH);
            m_valid <= lvl_nxt != '0;
            if (lvl_nxt != '0) {m_addr, m_data} <= head;
            ovf     <= drop | (ovf & ~ovf_clr);
        end
    end

`ifdef PROC_OUT_FIFO_DROPCNT_EN
    always_ff @(posedge clk) begin
        if (rst) dropcnt <= '0;
        else if (drop) dropcnt <= ovf_clr ? 16'd1 : (dropcnt == 16'hFFFF ? dropcnt : dropcnt + 16'd1);
        else if (ovf_clr) dropcnt <= '0;
    end
`endif
endmodule

// File: doc/proc_out_fifo.md
Name: proc_out_fifo

Overview:
- Output-side stage directly downstream of the fixed-point processor's output port.
- Captures every processor output write (`out_en`, `addr_out`, `io_out`) into a tagged FIFO, so bursts of writes are never lost while the sink stalls.
- Drains the tagged words to a peripheral or bus through a `valid`/`ready` stream interface.
- Reports fill level and a sticky overflow flag.

Parameters:
- NUBITS, 16, processor word width; equals the processor's NUBITS.
- NUIOOU, 2, number of output addresses; must be >= 2.
- FDEPTH, 8, FIFO depth in entries; power of 2, >= 2.
- NBADDR, $clog2(NUIOOU), width of the address tag.
- FDEPW, $clog2(FDEPTH), pointer width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- out_en  in  1  processor output write strobe, one word per high cycle.
- addr_out  in  NBADDR  output address from the processor, valid when out_en=1.
- io_out  in  NUBITS  output data from the processor, valid when out_en=1.
- m_valid  out  1  head entry is available to the sink.
- m_ready  in  1  sink accepts the head entry this cycle.
- m_data  out  NUBITS  head entry data.
- m_addr  out  NBADDR  head entry address tag.
- full  out  1  level == FDEPTH.
- empty  out  1  level == 0.
- level  out  FDEPW+1  current occupancy, 0..FDEPTH.
- ovf  out  1  sticky: at least one write was dropped.
- ovf_clr  in  1  clears ovf (synchronous).

Behaviour:
- Interface: one clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - Pointers = 0, level = 0.
  - empty = 1, full = 0, m_valid = 0, ovf = 0.
  - m_data = 0, m_addr = 0.
  - Storage contents are not reset.
- Reset mid-operation: all pending entries are discarded. An out_en asserted in the same cycle as rst is ignored.
- Push: `push = out_en & (~full | pop)`.
  - Writes {addr_out, io_out} at the write pointer; the pointer wraps modulo FDEPTH.
- Pop: `pop = m_valid & m_ready`.
  - Advances the read pointer, wrapping modulo FDEPTH.
  - m_ready while m_valid=0 has no effect.
- Simultaneous push and pop: level is unchanged. This holds when full (write into the slot freed this cycle, no drop) and when level = 1.
- Output is show-ahead (first-word-fall-through):
  - m_data/m_addr present the head entry and are registered.
  - A write at edge k into an empty FIFO gives m_valid=1 with that data after edge k.
  - Latency is 1 cycle from out_en to m_valid.
- m_data/m_addr hold stable while m_valid=1 and m_ready=0.
- Overflow:
  - Condition: out_en & full & ~pop.
  - The word is dropped, ovf is set to 1, and storage, level and pointers are unchanged.
- ovf_clr:
  - Clears ovf at the next edge.
  - If an overflow and ovf_clr occur in the same cycle, set wins (ovf = 1).
- level update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
  - full and empty are derived registered from level.
- Order: strict FIFO order across all addresses. The address tag travels with each word.
- No state machine beyond the pointer/level registers.

Optional Feature:
- Macro: PROC_OUT_FIFO_DROPCNT_EN.
- Defined:
  - Adds output port dropcnt (16 bits): a saturating count of dropped words.
  - Reset value 0.
  - Cleared by ovf_clr in the same cycle that ovf clears.
  - If a drop coincides with ovf_clr, dropcnt becomes 1.
  - Saturates at 16'hFFFF.
- Not defined: the port and the counter are absent; ovf behaves identically.

Decomposition:
- Package proc_io_pkg holds:
  - Localparam function for the entry width (NUBITS+NBADDR).
  - Entry struct typedef {addr, data}.
  - Shared by the future input-side FIFO.
- Sub-module fifo_ram_2p: simple dual-port storage with one write port and a combinational read port, parameterised by width and depth. Pointer/level/flag logic stays in proc_out_fifo.

Test Plan:
- Reset then single write:
  - Stimulus: out_en=1, addr_out=1, io_out=16'h1234 at edge 1, with m_ready=0.
  - Response: m_valid=1, m_addr=1, m_data=16'h1234, level=1 after edge 1. Data held while m_ready=0.
- Fill to full:
  - Stimulus: 8 consecutive writes of 0..7 with m_ready=0.
  - Response: full=1, level=8.
  - Then a 9th write of 16'hDEAD: ovf=1, level=8.
  - Draining yields 0..7 in order; 16'hDEAD is never emitted.
- Simultaneous push/pop at full:
  - Stimulus: full with 0..7, then out_en=1 (value 8) with m_ready=1.
  - Response: ovf stays 0, level=8.
  - Drain sequence is 1..8.
- Wrap-around:
  - Stimulus: 20 words streamed with m_ready=1 continuously.
  - Response: all 20 received in order with tags intact, level ≤ 1 throughout.
- ovf_clr vs drop:
  - Stimulus: full, then one cycle with out_en=1, ovf_clr=1, m_ready=0.
  - Response: ovf=1 (set wins). With DROPCNT_EN: dropcnt=1.
  - Next cycle ovf_clr alone: ovf=0, dropcnt=0.
- Reset mid-operation:
  - Stimulus: level=5, then rst=1 concurrent with out_en=1.
  - Response: after the edge, level=0, empty=1, m_valid=0, ovf=0.
